// File: rtl/modexp_ctrl.sv
// -----------------------------------------------------------------------------
// modexp_ctrl
// Sequencer for a word-serial modular exponentiation engine. Captures five
// wide operands on start, streams them to the engine one word per cycle
// (LOAD), waits for the engine to report COMPLETE (WAIT), then collects the
// result words (READ) and pulses done.
//
// Optional feature macro: MODEXP_CTRL_TIMEOUT_EN
//   defined   : a watchdog bounds WAIT to TIMEOUT_CYCLES cycles; on expiry the
//               operation ends with done=1, error=1 and result=0.
//   undefined : WAIT is unbounded, no watchdog logic, error is tied to 0.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start                       begin an operation (honoured only when idle)
//   message/exponent/modulus/
//   r_val/t_val                 operands, DATA_WIDTH*NUM_WORDS bits each
//   nprime0_in                  -n^-1 mod 2^DATA_WIDTH, latched on start
//   busy, done, error           status; done is a one-cycle pulse
//   result                      collected result words
//   m_buf/e_buf/n_buf/
//   r_buf/t_buf, nprime0        operand words and constant to the engine
//   startInput, startCompute,
//   getResult                   engine controls
//   exp_state, res_out          engine state and result word
// -----------------------------------------------------------------------------
module modexp_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_WORDS      = 64,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  message,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  exponent,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  modulus,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  r_val,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  t_val,
    input  logic [DATA_WIDTH-1:0]            nprime0_in,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [DATA_WIDTH*NUM_WORDS-1:0]  result,
    output logic [DATA_WIDTH-1:0]            m_buf,
    output logic [DATA_WIDTH-1:0]            e_buf,
    output logic [DATA_WIDTH-1:0]            n_buf,
    output logic [DATA_WIDTH-1:0]            r_buf,
    output logic [DATA_WIDTH-1:0]            t_buf,
    output logic [DATA_WIDTH-1:0]            nprime0,
    output logic                             startInput,
    output logic                             startCompute,
    output logic                             getResult,
    input  logic [4:0]                       exp_state,
    input  logic [DATA_WIDTH-1:0]            res_out
);

    // state  | meaning
    // IDLE   | waiting for start; done pulses here for one cycle
    // LOAD   | streaming operand word cnt to the engine
    // WAIT   | engine computing, waiting for exp_state == COMPLETE
    // READ   | cnt 0 skips engine latency, cnt j stores result word j-1

    localparam int         OP_W         = DATA_WIDTH * NUM_WORDS;
    localparam int         CNT_W        = $clog2(NUM_WORDS + 1);
    localparam int         WIDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [4:0] EXP_COMPLETE = 5'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_READ
    } state_t;

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 done_q, done_d;
    logic [OP_W-1:0]                      m_sr_q, e_sr_q, n_sr_q, r_sr_q, t_sr_q;
    logic [DATA_WIDTH-1:0]                np_q;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] result_q;
    logic [WIDX_W-1:0]                    rd_idx;
    logic                                 accept;
    logic                                 wd_expired;

    // The done cycle is spent in IDLE; a start coinciding with it is dropped.
    assign accept = (state_q == S_IDLE) && start && !done_q;
    assign rd_idx = WIDX_W'(cnt_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            m_sr_q   <= '0;
            e_sr_q   <= '0;
            n_sr_q   <= '0;
            r_sr_q   <= '0;
            t_sr_q   <= '0;
            np_q     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (accept) begin
                m_sr_q   <= message;
                e_sr_q   <= exponent;
                n_sr_q   <= modulus;
                r_sr_q   <= r_val;
                t_sr_q   <= t_val;
                np_q     <= nprime0_in;
                result_q <= '0;
            end else if (state_q == S_LOAD) begin
                m_sr_q <= m_sr_q >> DATA_WIDTH;
                e_sr_q <= e_sr_q >> DATA_WIDTH;
                n_sr_q <= n_sr_q >> DATA_WIDTH;
                r_sr_q <= r_sr_q >> DATA_WIDTH;
                t_sr_q <= t_sr_q >> DATA_WIDTH;
            end
            if (state_q == S_READ && cnt_q != '0) begin
                result_q[rd_idx] <= res_out;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (exp_state == EXP_COMPLETE) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q == CNT_W'(NUM_WORDS)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        startInput   = (state_q == S_LOAD);
        startCompute = (state_q == S_WAIT) || (state_q == S_READ);
        getResult    = startCompute;
        m_buf        = '0;
        e_buf        = '0;
        n_buf        = '0;
        r_buf        = '0;
        t_buf        = '0;
        if (state_q == S_LOAD) begin
            m_buf = m_sr_q[DATA_WIDTH-1:0];
            e_buf = e_sr_q[DATA_WIDTH-1:0];
            n_buf = n_sr_q[DATA_WIDTH-1:0];
            r_buf = r_sr_q[DATA_WIDTH-1:0];
            t_buf = t_sr_q[DATA_WIDTH-1:0];
        end
    end

    assign done    = done_q;
    assign nprime0 = np_q;
    assign result  = result_q;

`ifdef MODEXP_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_q;
    logic            error_q;

    // Down-counter preloaded during LOAD; reaching zero in WAIT means
    // TIMEOUT_CYCLES cycles have been spent waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if (state_q == S_WAIT && wd_q != '0) begin
                wd_q <= wd_q - WD_W'(1);
            end
            if (accept) begin
                error_q <= 1'b0;
            end else if (state_q == S_WAIT && state_d == S_IDLE) begin
                error_q <= 1'b1;
            end
        end
    end

    assign wd_expired = (wd_q == '0);
    assign error      = error_q;
`else
    assign wd_expired = 1'b0;
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;

    localparam int DW = 64;
    localparam int NW = 64;
    localparam int OW = DW * NW;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [OW-1:0] message, exponent, modulus, r_val, t_val;
    logic [DW-1:0] nprime0_in;
    logic          busy, done, error;
    logic [OW-1:0] result;
    logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
    logic          startInput, startCompute, getResult;
    logic [4:0]    exp_state = 5'd0;
    logic [DW-1:0] res_out = '0;

    always #5 clk = ~clk;

    modexp_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .message(message), .exponent(exponent), .modulus(modulus),
        .r_val(r_val), .t_val(t_val), .nprime0_in(nprime0_in),
        .busy(busy), .done(done), .error(error), .result(result),
        .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
        .nprime0(nprime0), .startInput(startInput), .startCompute(startCompute),
        .getResult(getResult), .exp_state(exp_state), .res_out(res_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        int w;
        total++;
        if (act !== exp) begin
            bad++;
            w = 0;
            for (int i = NW - 1; i >= 0; i--)
                if (act[i*DW +: DW] !== exp[i*DW +: DW]) w = i;
            $display("FAIL %s cyc=%0d word %0d: got %h expected %h",
                     name, cyc, w, act[w*DW +: DW], exp[w*DW +: DW]);
        end
    endtask

    // ---------------- engine stand-in ----------------
    // mode 0: COMPLETE after eng_lat non-complete WAIT cycles
    // mode 1: never COMPLETE
    // mode 2: exp_state held at COMPLETE all the time
    // Result word j is presented two cycles after COMPLETE plus j.
    int            eng_mode = 0, eng_lat = 0, eng_cnt = 0, eng_d = -1;
    logic [DW-1:0] eng_vals [NW];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!startCompute) begin
                eng_cnt   = 0;
                eng_d     = -1;
                exp_state = (eng_mode == 2) ? 5'd9 : 5'($urandom_range(0, 9));
            end else begin
                if (eng_d < 0) begin
                    if (eng_mode != 1 && eng_cnt >= eng_lat) eng_d = 0;
                    else eng_cnt++;
                end else begin
                    eng_d++;
                end
                if (eng_d == 0 || eng_mode == 2) exp_state = 5'd9;
                else if (eng_d < 0)              exp_state = 5'($urandom_range(0, 8));
                else                             exp_state = 5'($urandom_range(0, 9));
            end
            res_out = (eng_d >= 2 && eng_d - 2 < NW) ? eng_vals[eng_d-2] : {$urandom, $urandom};
        end
    end

    // ---------------- reference model (timestamps) ----------------
    // t_s: cycle start was accepted, loads run t_s+1 .. t_s+NW,
    // t_w: first wait cycle, t_r: first read cycle, t_d: done cycle.
    bit            m_on = 0, m_act = 0, m_err = 0;
    int            t_s = 0, t_w = 0, t_r = -1, t_d = -1;
    logic [OW-1:0] cap_m, cap_e, cap_n, cap_r, cap_t, m_res;
    logic [DW-1:0] m_np;

    initial begin : model
        int prev;
        forever begin
            @(posedge clk);
            cyc++;
            prev = cyc - 1;
            if (reset) begin
                m_on = 1; m_act = 0; m_err = 0; m_res = '0; m_np = '0; t_d = -1; t_r = -1;
            end else if (!m_act) begin
                if (start && prev != t_d) begin
                    m_act = 1; m_err = 0; m_res = '0; m_np = nprime0_in;
                    cap_m = message; cap_e = exponent; cap_n = modulus; cap_r = r_val; cap_t = t_val;
                    t_s = prev; t_w = prev + NW + 1; t_r = -1;
                end
            end else if (t_r < 0) begin
                if (prev >= t_w) begin
                    if (exp_state == 5'd9) t_r = cyc;
`ifdef MODEXP_CTRL_TIMEOUT_EN
                    else if (prev - t_w + 1 == TO) begin
                        m_act = 0; m_err = 1; t_d = cyc;
                    end
`endif
                end
            end else begin
                if (prev > t_r) m_res[(prev - t_r - 1)*DW +: DW] = res_out;
                if (prev - t_r == NW) begin
                    m_act = 0; t_d = cyc;
                end
            end
        end
    end

    initial begin : compare
        bit ld, cp;
        int k;
        forever begin
            @(negedge clk);
            if (m_on) begin
                ld = m_act && (cyc < t_w);
                cp = m_act && (cyc >= t_w);
                k  = ld ? (cyc - t_s - 1) : 0;
                chk("busy", busy, m_act);
                chk("done", done, cyc == t_d);
                chk("error", error, m_err);
                chk("result", result, m_res);
                chk("nprime0", nprime0, m_np);
                chk("startInput", startInput, ld);
                chk("startCompute", startCompute, cp);
                chk("getResult", getResult, cp);
                chk("m_buf", m_buf, ld ? cap_m[k*DW +: DW] : DW'(0));
                chk("e_buf", e_buf, ld ? cap_e[k*DW +: DW] : DW'(0));
                chk("n_buf", n_buf, ld ? cap_n[k*DW +: DW] : DW'(0));
                chk("r_buf", r_buf, ld ? cap_r[k*DW +: DW] : DW'(0));
                chk("t_buf", t_buf, ld ? cap_t[k*DW +: DW] : DW'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [OW-1:0] rnd_op();
        logic [OW-1:0] v;
        for (int i = 0; i < OW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_operands();
        message = rnd_op(); exponent = rnd_op(); modulus = rnd_op();
        r_val = rnd_op(); t_val = rnd_op(); nprime0_in = {$urandom, $urandom};
        for (int j = 0; j < NW; j++) eng_vals[j] = {$urandom, $urandom};
    endtask

    int            n_load, n_sc;
    bit            got_done;
    logic [DW-1:0] mb_seen [NW];
    logic [DW-1:0] nb_seen [NW];

    // Issue one start, observe until done (or budget), optionally poking start
    // while busy and on the done cycle itself.
    task automatic do_op(input string name, input bit poke, input int budget);
        n_load = 0; n_sc = 0; got_done = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < budget && !got_done; i++) begin
            if (startInput) begin
                if (n_load < NW) begin
                    mb_seen[n_load] = m_buf;
                    nb_seen[n_load] = n_buf;
                end
                n_load++;
            end
            if (startCompute) n_sc++;
            if (done) got_done = 1;
            start = poke && (i == 10 || i == NW || i == NW + eng_lat + 20 || done);
            tick();
        end
        start = 0;
        chk({name, "_reached_done"}, got_done, 1'b1);
    endtask

    initial begin : global_limit
        #2000000;
        bad++;
        $display("FAIL global_time_limit cyc=%0d: got no finish expected finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stim
        int            nmis, dcnt;
        logic [OW-1:0] expv;
        reset = 1; start = 0;
        message = '0; exponent = '0; modulus = '0; r_val = '0; t_val = '0; nprime0_in = '0;
        for (int j = 0; j < NW; j++) eng_vals[j] = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_startCompute", startCompute, 0);
        reset = 0;
        tick();

        // basic operation
        message = '0; message[DW-1:0] = 64'd8;
        exponent = '0; exponent[DW-1:0] = 64'd13;
        modulus = '0; modulus[DW-1:0] = 64'd77;
        r_val = rnd_op(); t_val = rnd_op(); nprime0_in = 64'h0123_4567_89ab_cdef;
        for (int j = 0; j < NW; j++) eng_vals[j] = '0;
        eng_vals[0] = 64'd57;
        eng_mode = 0; eng_lat = 3;
        do_op("basic", 0, 400);
        chk("basic_load_cycles", n_load, 64);
        chk("basic_mbuf_w0", mb_seen[0], 8);
        nmis = 0;
        for (int k = 1; k < NW; k++) if (mb_seen[k] !== '0) nmis++;
        chk("basic_mbuf_upper_zero", nmis, 0);
        chk("basic_compute_cycles", n_sc, 69);
        chk("basic_result", result, 57);
        chk("basic_error", error, 0);
        chk("basic_nprime0", nprime0, 64'h0123_4567_89ab_cdef);

        // word ordering
        rand_operands();
        for (int i = 0; i < NW; i++) modulus[i*DW +: DW] = DW'(i);
        for (int j = 0; j < NW; j++) eng_vals[j] = DW'(32'hA5 + j);
        eng_lat = 5;
        do_op("order", 0, 400);
        nmis = 0;
        for (int k = 0; k < NW; k++) if (nb_seen[k] !== DW'(k)) nmis++;
        chk("order_nbuf_words", nmis, 0);
        nmis = 0;
        for (int j = 0; j < NW; j++) if (result[j*DW +: DW] !== DW'(32'hA5 + j)) nmis++;
        chk("order_result_words", nmis, 0);

        // start while busy, and on the done cycle
        rand_operands();
        eng_lat = 30;
        do_op("busy_start", 1, 400);
        chk("busy_start_load_cycles", n_load, 64);
        chk("busy_start_compute_cycles", n_sc, 30 + 66);
        chk("start_at_done_ignored", busy, 0);
        dcnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        chk("busy_start_no_restart", dcnt, 0);

        // reset mid-LOAD
        rand_operands();
        start = 1; tick(); start = 0;
        repeat (30) tick();
        chk("midrst_in_load", startInput, 1);
        reset = 1; tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_startInput", startInput, 0);
        chk("midrst_nbuf", n_buf, 0);
        chk("midrst_nprime0", nprime0, 0);
        chk("midrst_result", result, 0);
        reset = 0; tick();
        rand_operands();
        eng_lat = 2;
        do_op("after_rst", 0, 400);
        for (int j = 0; j < NW; j++) expv[j*DW +: DW] = eng_vals[j];
        chk("after_rst_result", result, expv);

        // engine never completes
        rand_operands();
        eng_mode = 1;
`ifdef MODEXP_CTRL_TIMEOUT_EN
        do_op("timeout", 0, 400);
        chk("timeout_wait_cycles", n_sc, TO);
        chk("timeout_error", error, 1);
        chk("timeout_result", result, 0);
        chk("timeout_startCompute", startCompute, 0);
`else
        start = 1; tick(); start = 0;
        dcnt = 0;
        for (int i = 0; i < NW + 2 * TO; i++) begin
            if (done) dcnt++;
            tick();
        end
        chk("nolimit_no_done", dcnt, 0);
        chk("nolimit_still_busy", busy, 1);
        chk("nolimit_error", error, 0);
        reset = 1; tick(); reset = 0; tick();
`endif

        // COMPLETE already asserted during LOAD
        rand_operands();
        eng_mode = 2; eng_lat = 0;
        do_op("early", 0, 400);
        chk("early_load_cycles", n_load, 64);
        chk("early_compute_cycles", n_sc, 66);
        eng_mode = 0;

        // randomized operations
        for (int n = 0; n < 12; n++) begin
            rand_operands();
            eng_lat = $urandom_range(0, 15);
            do_op("rand", 1'($urandom_range(0, 1)), 400);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
